// File: rtl/hazard_pipe_pkg.sv
// hazard_pipe_pkg: shared encodings, stage types and bubble constants for hazard_pipe
package hazard_pipe_pkg;
  localparam logic [1:0] TUSE_NONE = 2'b11;
  localparam logic [1:0] TNEW_LINK = 2'd0;
  localparam logic [1:0] TNEW_ALU = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;
  localparam logic [1:0] MD_NONE = 2'b00;
  localparam logic [1:0] MD_MULT = 2'b01;
  localparam logic [1:0] MD_DIV = 2'b10;
  localparam logic [1:0] MD_HILO = 2'b11;
  typedef struct packed {
    logic [4:0] a1;
    logic [4:0] a2;
    logic [4:0] a3;
    logic       reg_write;
    logic       jal;
    logic       jalr;
    logic [1:0] tnew;
    logic [1:0] md;
  } e_stage_t;
  typedef struct packed {
    logic [4:0] a2;
    logic [4:0] a3;
    logic       reg_write;
    logic       jal;
    logic       jalr;
    logic [1:0] tnew;
  } m_stage_t;
  typedef struct packed {
    logic [4:0] a3;
    logic       reg_write;
    logic       jal;
    logic       jalr;
    logic [1:0] tnew;
  } w_stage_t;
  localparam e_stage_t E_BUBBLE = '0;
  localparam m_stage_t M_BUBBLE = '0;
  localparam w_stage_t W_BUBBLE = '0;
  function automatic logic [1:0] sat_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction
  function automatic logic is_md_start(input logic [1:0] md);
    return (md == MD_MULT) || (md == MD_DIV);
  endfunction
endpackage

// File: rtl/hazard_pipe_md_busy_ctr.sv
// md_busy_ctr: multiply/divide occupancy countdown
module md_busy_ctr
  import hazard_pipe_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] md_e,
  output logic       md_busy
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int W = $clog2(MAX_CYCLES + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= (md_e == MD_MULT) ? W'(MULT_CYCLES) :
                (md_e == MD_DIV) ? W'(DIV_CYCLES) :
                (cnt != '0) ? cnt - W'(1) : '0;
  assign md_busy = is_md_start(md_e) || (cnt != '0);
endmodule

// File: rtl/hazard_pipe.sv
// hazard_pipe: E/M/W control pipeline with Tuse/Tnew stall detection and mult/div busy tracking
module hazard_pipe
  import hazard_pipe_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] A1_D,
  input  logic [4:0] A2_D,
  input  logic [1:0] Tuse_rs_D,
  input  logic [1:0] Tuse_rt_D,
  input  logic [4:0] A3_D,
  input  logic [1:0] Tnew_D,
  input  logic       RegWrite_D,
  input  logic       jal_D,
  input  logic       jalr_D,
  input  logic [1:0] md_D,
  output logic       stall,
  output logic [4:0] A1_E,
  output logic [4:0] A2_E,
  output logic [4:0] A2_M,
  output logic [4:0] A3_E,
  output logic [4:0] A3_M,
  output logic [4:0] A3_W,
  output logic       RegWrite_E,
  output logic       RegWrite_M,
  output logic       RegWrite_W,
  output logic       jal_E,
  output logic       jal_M,
  output logic       jal_W,
  output logic       jalr_E,
  output logic       jalr_M,
  output logic       jalr_W,
  output logic [1:0] Tnew_E,
  output logic [1:0] Tnew_M,
  output logic [1:0] Tnew_W,
  output logic       md_busy
);
  e_stage_t d, e;
  m_stage_t m;
  w_stage_t w;
  logic live_e, live_m, haz_rs, haz_rt, md_stall;
  assign d = '{a1: A1_D, a2: A2_D, a3: A3_D, reg_write: RegWrite_D, jal: jal_D,
               jalr: jalr_D, tnew: Tnew_D, md: md_D};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      e <= E_BUBBLE;
      m <= M_BUBBLE;
      w <= W_BUBBLE;
    end else begin
      e <= stall ? E_BUBBLE : d;
      m <= '{a2: e.a2, a3: e.a3, reg_write: e.reg_write, jal: e.jal, jalr: e.jalr,
             tnew: sat_dec(e.tnew)};
      w <= '{a3: m.a3, reg_write: m.reg_write, jal: m.jal, jalr: m.jalr,
             tnew: sat_dec(m.tnew)};
    end
  md_busy_ctr #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_md (
    .clk(clk), .reset_n(reset_n), .md_e(e.md), .md_busy(md_busy)
  );
  assign live_e = e.reg_write && (e.a3 != 5'd0);
  assign live_m = m.reg_write && (m.a3 != 5'd0);
  assign haz_rs = (Tuse_rs_D != TUSE_NONE) &&
                  ((live_e && A1_D == e.a3 && Tuse_rs_D < e.tnew) ||
                   (live_m && A1_D == m.a3 && Tuse_rs_D < m.tnew));
  assign haz_rt = (Tuse_rt_D != TUSE_NONE) &&
                  ((live_e && A2_D == e.a3 && Tuse_rt_D < e.tnew) ||
                   (live_m && A2_D == m.a3 && Tuse_rt_D < m.tnew));
  assign md_stall = (md_D != MD_NONE) && (md_busy || is_md_start(e.md));
  assign stall = reset_n && (haz_rs || haz_rt || md_stall);
  assign A1_E = e.a1;
  assign A2_E = e.a2;
  assign A2_M = m.a2;
  assign A3_E = e.a3;
  assign A3_M = m.a3;
  assign A3_W = w.a3;
  assign RegWrite_E = e.reg_write;
  assign RegWrite_M = m.reg_write;
  assign RegWrite_W = w.reg_write;
  assign jal_E = e.jal;
  assign jal_M = m.jal;
  assign jal_W = w.jal;
  assign jalr_E = e.jalr;
  assign jalr_M = m.jalr;
  assign jalr_W = w.jalr;
  assign Tnew_E = e.tnew;
  assign Tnew_M = m.tnew;
  assign Tnew_W = w.tnew;
endmodule

// File: tb/tb_hazard_pipe.sv
// tb_hazard_pipe: directed self-checking bench for hazard_pipe
module tb_hazard_pipe;
  logic clk = 0, reset_n = 0;
  logic [4:0] A1_D, A2_D, A3_D;
  logic [1:0] Tuse_rs_D, Tuse_rt_D, Tnew_D, md_D;
  logic RegWrite_D, jal_D, jalr_D;
  logic stall, md_busy;
  logic [4:0] A1_E, A2_E, A2_M, A3_E, A3_M, A3_W;
  logic RegWrite_E, RegWrite_M, RegWrite_W, jal_E, jal_M, jal_W, jalr_E, jalr_M, jalr_W;
  logic [1:0] Tnew_E, Tnew_M, Tnew_W;
  int n_tests = 0, n_fail = 0, n_stall;
  hazard_pipe dut (
    .clk(clk), .reset_n(reset_n), .A1_D(A1_D), .A2_D(A2_D), .Tuse_rs_D(Tuse_rs_D),
    .Tuse_rt_D(Tuse_rt_D), .A3_D(A3_D), .Tnew_D(Tnew_D), .RegWrite_D(RegWrite_D),
    .jal_D(jal_D), .jalr_D(jalr_D), .md_D(md_D), .stall(stall), .A1_E(A1_E), .A2_E(A2_E),
    .A2_M(A2_M), .A3_E(A3_E), .A3_M(A3_M), .A3_W(A3_W), .RegWrite_E(RegWrite_E),
    .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W), .jal_E(jal_E), .jal_M(jal_M),
    .jal_W(jal_W), .jalr_E(jalr_E), .jalr_M(jalr_M), .jalr_W(jalr_W), .Tnew_E(Tnew_E),
    .Tnew_M(Tnew_M), .Tnew_W(Tnew_W), .md_busy(md_busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic set_d(input logic [4:0] a1, input logic [4:0] a2, input logic [1:0] urs,
                       input logic [1:0] urt, input logic [4:0] a3, input logic [1:0] tn,
                       input logic rw, input logic jl, input logic jr, input logic [1:0] md);
    A1_D = a1; A2_D = a2; Tuse_rs_D = urs; Tuse_rt_D = urt; A3_D = a3; Tnew_D = tn;
    RegWrite_D = rw; jal_D = jl; jalr_D = jr; md_D = md;
    #1;
  endtask
  task automatic nop();
    set_d(0, 0, 3, 3, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic count_stall(input string tag, input int exp);
    n_stall = 0;
    while (stall && n_stall < 40) begin
      n_stall++;
      step();
    end
    chk(tag, n_stall, exp);
    chk({tag, "_busy_off"}, md_busy, 0);
  endtask
  initial begin
    set_d(0, 0, 3, 3, 0, 0, 0, 0, 0, 2'b11);
    #12;
    chk("rst_stall", stall, 0);
    chk("rst_a3e", A3_E, 0);
    chk("rst_rwe", RegWrite_E, 0);
    chk("rst_busy", md_busy, 0);
    nop();
    reset_n = 1;
    step();
    // lw $8 then addu $9,$8,$1
    set_d(4, 0, 1, 3, 8, 2, 1, 0, 0, 0);
    step();
    chk("lw_a3e", A3_E, 8);
    chk("lw_tnewe", Tnew_E, 2);
    set_d(8, 1, 1, 1, 9, 1, 1, 0, 0, 0);
    chk("lw_use_stall", stall, 1);
    step();
    chk("lw_a3m", A3_M, 8);
    chk("lw_tnewm", Tnew_M, 1);
    chk("lw_bubble_a3e", A3_E, 0);
    chk("lw_stall_gone", stall, 0);
    step();
    chk("addu_a3e", A3_E, 9);
    chk("addu_a2e", A2_E, 1);
    nop();
    step(); step(); step();
    // addu $8 then beq $8
    set_d(2, 3, 1, 1, 8, 1, 1, 0, 0, 0);
    step();
    set_d(8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("beq_stall", stall, 1);
    step();
    chk("beq_stall_gone", stall, 0);
    chk("beq_tnewm", Tnew_M, 0);
    step();
    // ori $8 two ahead of beq
    set_d(0, 0, 1, 3, 8, 1, 1, 0, 0, 0);
    step();
    nop();
    step();
    set_d(8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("ori_no_stall", stall, 0);
    step();
    nop();
    step(); step();
    // jal then jr $31
    set_d(0, 0, 3, 3, 31, 0, 1, 1, 0, 0);
    step();
    chk("jal_e", jal_E, 1);
    chk("jal_a3e", A3_E, 31);
    set_d(31, 0, 0, 3, 0, 0, 0, 0, 1, 0);
    chk("jr_no_stall", stall, 0);
    step();
    chk("jal_m", jal_M, 1);
    chk("jr_jalr_e", jalr_E, 1);
    nop();
    step();
    chk("jal_w", jal_W, 1);
    chk("jal_a3w", A3_W, 31);
    chk("jal_tnew_sat", Tnew_W, 0);
    chk("jalr_m", jalr_M, 1);
    step(); step();
    // mult then mfhi
    set_d(2, 3, 1, 1, 0, 0, 0, 0, 0, 2'b01);
    step();
    chk("mult_busy", md_busy, 1);
    set_d(0, 0, 3, 3, 10, 1, 1, 0, 0, 2'b11);
    count_stall("mult_stall", 6);
    step();
    nop();
    step(); step();
    // div then mflo
    set_d(2, 3, 1, 1, 0, 0, 0, 0, 0, 2'b10);
    step();
    set_d(0, 0, 3, 3, 11, 1, 1, 0, 0, 2'b11);
    count_stall("div_stall", 11);
    step();
    nop();
    step(); step();
    // write to $0 then use $0
    set_d(4, 0, 1, 3, 0, 2, 1, 0, 0, 0);
    step();
    chk("zero_rwe", RegWrite_E, 1);
    set_d(0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
    chk("zero_stall_e", stall, 0);
    step();
    chk("zero_stall_m", stall, 0);
    nop();
    step(); step();
    // reset mid-countdown
    set_d(2, 3, 1, 1, 0, 0, 0, 0, 0, 2'b10);
    step();
    set_d(1, 2, 1, 1, 5, 1, 1, 0, 0, 0);
    step(); step(); step(); step();
    chk("cnt7_busy", md_busy, 1);
    chk("cnt7_a3m", A3_M, 5);
    #1 reset_n = 0;
    #1;
    chk("arst_busy", md_busy, 0);
    chk("arst_a3", {A3_E, A3_M, A3_W}, 0);
    chk("arst_rw", {RegWrite_E, RegWrite_M, RegWrite_W}, 0);
    chk("arst_stall", stall, 0);
    step();
    reset_n = 1;
    set_d(0, 0, 3, 3, 10, 1, 1, 0, 0, 2'b11);
    chk("arst_no_residual", stall, 0);
    step();
    chk("post_rst_adv", A3_E, 10);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
